// File: rtl/systolic_drain_if.sv
// Handshake and data bundle between the systolic array bottom row,
// the drain block and the result writeback path.
interface systolic_drain_if #(
  parameter int ARR_SIZE    = 4,
  parameter int VERTICAL_BW = 32,
  parameter int DEPTH       = 4
);
  localparam int ROW_W = ARR_SIZE * VERTICAL_BW;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ROW_W-1:0] i_array_op;
  logic             i_row_valid;
  logic [ROW_W-1:0] o_data;
  logic             o_valid;
  logic             i_ready;
  logic [CNT_W-1:0] o_count;
  logic             o_overflow;

  // Upstream/downstream side (array plus writeback path).
  modport master (
    output i_array_op, i_row_valid, i_ready,
    input  o_data, o_valid, o_count, o_overflow
  );

  // Drain block side.
  modport slave (
    input  i_array_op, i_row_valid, i_ready,
    output o_data, o_valid, o_count, o_overflow
  );
endinterface

// File: rtl/systolic_drain.sv
// Deskews the systolic array bottom-row bus (column k lags column 0 by k
// cycles) into whole rows and buffers them in a first-word-fall-through FIFO.
module systolic_drain #(
  parameter int ARR_SIZE    = 4,
  parameter int VERTICAL_BW = 32,
  parameter int DEPTH       = 4
) (
  input logic              clk,
  input logic              rst,
  systolic_drain_if.slave  bus
);
  localparam int ROW_W = ARR_SIZE * VERTICAL_BW;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ROW_W-1:0] aligned_row;
  logic             aligned_valid;

  // Column k is delayed ARR_SIZE-1-k cycles so every column lines up with the
  // last one, which is taken straight off the bus.
  for (genvar k = 0; k < ARR_SIZE; k++) begin : g_col
    localparam int NS = ARR_SIZE - 1 - k;
    if (NS == 0) begin : g_pass
      assign aligned_row[k*VERTICAL_BW +: VERTICAL_BW] = bus.i_array_op[k*VERTICAL_BW +: VERTICAL_BW];
    end else begin : g_dly
      logic [VERTICAL_BW-1:0] stg [NS];
      // Shift the column word down its delay line.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < NS; i++) stg[i] <= '0;
        end else begin
          stg[0] <= bus.i_array_op[k*VERTICAL_BW +: VERTICAL_BW];
          for (int i = 1; i < NS; i++) stg[i] <= stg[i-1];
        end
      end
      assign aligned_row[k*VERTICAL_BW +: VERTICAL_BW] = stg[NS-1];
    end
  end

  // The row-valid tag travels alongside column 0 so it marks the aligned row.
  if (ARR_SIZE > 1) begin : g_tag
    logic [ARR_SIZE-2:0] tag;
    // Shift the row-valid tag.
    always_ff @(posedge clk) begin
      if (rst) begin
        tag <= '0;
      end else begin
        tag[0] <= bus.i_row_valid;
        for (int i = 1; i < ARR_SIZE - 1; i++) tag[i] <= tag[i-1];
      end
    end
    assign aligned_valid = tag[ARR_SIZE-2];
  end else begin : g_notag
    assign aligned_valid = bus.i_row_valid;
  end

  logic [ROW_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             full;
  logic             pop;
  logic             push;

  // A full FIFO still accepts a row when the head leaves in the same cycle.
  assign full = (count == CNT_W'(DEPTH));
  assign pop  = bus.o_valid && bus.i_ready;
  assign push = aligned_valid && (!full || pop);

  // Row storage; contents need no reset because the output is masked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= aligned_row;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (aligned_valid && full && !pop) overflow <= 1'b1;
    end
  end

  assign bus.o_valid    = (count != '0);
  assign bus.o_count    = count;
  assign bus.o_overflow = overflow;
  assign bus.o_data     = bus.o_valid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_systolic_drain.sv
// Randomised and directed bench for systolic_drain with a queue-based
// reference model and a negedge monitor.
module tb_systolic_drain;
  localparam int AS = 4;
  localparam int VB = 32;
  localparam int DP = 4;
  typedef logic [AS*VB-1:0] row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  systolic_drain_if #(.ARR_SIZE(AS), .VERTICAL_BW(VB), .DEPTH(DP)) bus_if ();

  systolic_drain #(.ARR_SIZE(AS), .VERTICAL_BW(VB), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;
  bit   m_ovf = 1'b0;
  row_t mq[$];
  row_t row_at [int];

  task automatic chk(input string nm, input logic [AS*VB-1:0] act, input logic [AS*VB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Monitor and reference model: compare visible state, then advance the model
  // with this cycle's inputs (a row issued at t is complete at t+AS-1).
  always @(negedge clk) begin
    bit do_pop;
    if (chk_en) begin
      chk("o_valid", row_t'(bus_if.o_valid), row_t'(mq.size() > 0));
      chk("o_count", row_t'(bus_if.o_count), row_t'(mq.size()));
      chk("o_overflow", row_t'(bus_if.o_overflow), row_t'(m_ovf));
      chk("o_data", bus_if.o_data, (mq.size() > 0) ? mq[0] : row_t'(0));
    end
    if (rst) begin
      mq.delete();
      row_at.delete();
      m_ovf  = 1'b0;
      chk_en = 1'b1;
    end else if (chk_en) begin
      do_pop = (mq.size() > 0) && bus_if.i_ready;
      if (do_pop) void'(mq.pop_front());
      if (row_at.exists(cyc - (AS - 1))) begin
        if (mq.size() < DP) mq.push_back(row_at[cyc - (AS - 1)]);
        else m_ovf = 1'b1;
      end
    end
  end

  function automatic row_t rand_row();
    row_t r;
    for (int k = 0; k < AS; k++) r[k*VB +: VB] = $urandom;
    return r;
  endfunction

  function automatic row_t pat_row(input int base);
    row_t r;
    for (int k = 0; k < AS; k++) r[k*VB +: VB] = 32'(base + k);
    return r;
  endfunction

  // Drive one cycle: a new row starts its column 0 now, earlier rows supply
  // their later columns, anything else on the bus is noise.
  task automatic step(input bit r, input bit rv, input bit rdy, input row_t row);
    @(posedge clk);
    #1;
    rst                = r;
    bus_if.i_row_valid = rv;
    bus_if.i_ready     = rdy;
    if (rv) row_at[cyc] = row;
    for (int k = 0; k < AS; k++) begin
      if (row_at.exists(cyc - k)) bus_if.i_array_op[k*VB +: VB] = row_at[cyc - k][k*VB +: VB];
      else                        bus_if.i_array_op[k*VB +: VB] = $urandom;
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rdy, '0);
  endtask

  initial begin
    bus_if.i_row_valid = 1'b0;
    bus_if.i_ready     = 1'b0;
    bus_if.i_array_op  = '0;

    // reset with bus noise
    for (int i = 0; i < 2; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_row());
    idle(2, 1'b1);

    // single row
    step(1'b0, 1'b1, 1'b1, pat_row(32'h100));
    idle(6, 1'b1);

    // streaming
    for (int r = 0; r < 3; r++) step(1'b0, 1'b1, 1'b1, pat_row(r * 16));
    idle(6, 1'b1);

    // backpressure and overflow
    for (int r = 0; r < 5; r++) step(1'b0, 1'b1, 1'b0, rand_row());
    idle(8, 1'b0);
    idle(8, 1'b1);

    // full with concurrent pop and write
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 12; i++) step(1'b0, (i < 4) || (i == 8), (i == 11), rand_row());
    idle(8, 1'b1);

    // reset mid-flight
    step(1'b0, 1'b1, 1'b1, rand_row());
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 1'b1, '0);
    idle(10, 1'b1);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6), rand_row());
    idle(10, 1'b1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
